// File: rtl/npc_fetch_f.sv
// Fetch-stage next-PC selection and F/D PC pipeline register.
// Optional macro NPC_FETCH_ADEL_EN builds the fetch-address legality check that drives adel_D.
module npc_fetch_f #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [31:0] EXC_HANDLER = 32'h0000_4180,
  parameter logic [31:0] IM_BASE     = 32'h0000_3000,
  parameter logic [31:0] IM_TOP      = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Branch,
  input  logic        is_branch_D,
  input  logic        is_j_D,
  input  logic        is_jr_D,
  input  logic [15:0] imm16_D,
  input  logic [25:0] index26_D,
  input  logic [31:0] rs_val_D,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  output logic [31:0] pc_F,
  output logic [31:0] pc_D,
  output logic        valid_D,
  output logic        bd_D,
  output logic        adel_D
);

  logic [31:0] pc_d_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;
  logic        flush;
  logic        br_taken;
  logic        j_taken;
  logic        jr_taken;
  logic        ctl_d;
  logic        illegal_f;

  if (IM_BASE > IM_TOP) begin : g_bad_im_range
    $error("npc_fetch_f: IM_BASE lies above IM_TOP");
  end

  // Control-transfer decode only counts for a real instruction in D.
  always_comb begin
    pc_d_plus4 = pc_D + 32'd4;
    br_target  = pc_d_plus4 + {{14{imm16_D[15]}}, imm16_D, 2'b00};
    j_target   = {pc_d_plus4[31:28], index26_D, 2'b00};
    flush      = exc_req | eret_req;
    br_taken   = valid_D & is_branch_D & Branch;
    j_taken    = valid_D & is_j_D;
    jr_taken   = valid_D & is_jr_D;
    ctl_d      = valid_D & (is_branch_D | is_j_D | is_jr_D);
  end

  always_comb begin
    pc_next = pc_F + 32'd4;
    if (exc_req)       pc_next = EXC_HANDLER;
    else if (eret_req) pc_next = epc;
    else if (stall)    pc_next = pc_F;
    else if (br_taken) pc_next = br_target;
    else if (j_taken)  pc_next = j_target;
    else if (jr_taken) pc_next = rs_val_D;
  end

`ifdef NPC_FETCH_ADEL_EN
  always_comb begin
    illegal_f = (pc_F[1:0] != 2'b00) | (pc_F < IM_BASE) | (pc_F > IM_TOP);
  end
`else
  always_comb begin
    illegal_f = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_F <= RESET_PC;
    end else begin
      pc_F <= pc_next;
    end
  end

  // A flush loads pc_D with the redirect target so CP0 sees where fetch resumes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_D    <= RESET_PC;
      valid_D <= 1'b0;
      bd_D    <= 1'b0;
      adel_D  <= 1'b0;
    end else if (flush) begin
      pc_D    <= pc_next;
      valid_D <= 1'b0;
      bd_D    <= 1'b0;
      adel_D  <= 1'b0;
    end else if (!stall) begin
      pc_D    <= pc_F;
      valid_D <= 1'b1;
      bd_D    <= ctl_d;
      adel_D  <= illegal_f;
    end
  end

endmodule

// File: tb/tb_npc_fetch_f.sv
// Directed self-checking bench for npc_fetch_f; adel_D expectations follow NPC_FETCH_ADEL_EN.
module tb_npc_fetch_f;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Branch;
  logic        is_branch_D;
  logic        is_j_D;
  logic        is_jr_D;
  logic [15:0] imm16_D;
  logic [25:0] index26_D;
  logic [31:0] rs_val_D;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc_F;
  logic [31:0] pc_D;
  logic        valid_D;
  logic        bd_D;
  logic        adel_D;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

`ifdef NPC_FETCH_ADEL_EN
  localparam logic ADEL_ON = 1'b1;
`else
  localparam logic ADEL_ON = 1'b0;
`endif

  npc_fetch_f #(
    .RESET_PC   (32'h0000_3000),
    .EXC_HANDLER(32'h0000_4180),
    .IM_BASE    (32'h0000_3000),
    .IM_TOP     (32'h0000_6ffc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .Branch     (Branch),
    .is_branch_D(is_branch_D),
    .is_j_D     (is_j_D),
    .is_jr_D    (is_jr_D),
    .imm16_D    (imm16_D),
    .index26_D  (index26_D),
    .rs_val_D   (rs_val_D),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .pc_F       (pc_F),
    .pc_D       (pc_D),
    .valid_D    (valid_D),
    .bd_D       (bd_D),
    .adel_D     (adel_D)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    Branch      = 1'b0;
    is_branch_D = 1'b0;
    is_j_D      = 1'b0;
    is_jr_D     = 1'b0;
    imm16_D     = '0;
    index26_D   = '0;
    rs_val_D    = '0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    stall    = 1'b0;
    exc_req  = 1'b0;
    eret_req = 1'b0;
    epc      = '0;
    clear_ctl();
    tick();
    tick();
    n_cmp++;
    if ({pc_F, pc_D, valid_D, bd_D, adel_D} !== {32'h3000, 32'h3000, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: pc_F=%h pc_D=%h v=%b bd=%b adel=%b want 3000 3000 0 0 0",
               pc_F, pc_D, valid_D, bd_D, adel_D);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({pc_F, valid_D} !== {32'h3000, 1'b0}) begin
      n_err++;
      $display("FAIL seq_c1: pc_F=%h v=%b want 3000 0", pc_F, valid_D);
    end
    for (int unsigned i = 1; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({pc_F, pc_D, valid_D, bd_D} !== {32'h3000 + 32'(4 * i), 32'h3000 + 32'(4 * (i - 1)), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL seq_c%0d: pc_F=%h pc_D=%h v=%b bd=%b want %h %h 1 0", i + 1, pc_F, pc_D,
                 valid_D, bd_D, 32'h3000 + 32'(4 * i), 32'h3000 + 32'(4 * (i - 1)));
      end
    end
  endtask

  // Entry: pc_F=300c, pc_D=3008.
  task automatic test_branch();
    is_branch_D = 1'b1; Branch = 1'b1; imm16_D = 16'h0003;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, valid_D, bd_D} !== {32'h3018, 32'h300c, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL br_taken: pc_F=%h pc_D=%h v=%b bd=%b want 3018 300c 1 1", pc_F, pc_D, valid_D, bd_D);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, bd_D} !== {32'h301c, 32'h3018, 1'b0}) begin
      n_err++;
      $display("FAIL br_after: pc_F=%h pc_D=%h bd=%b want 301c 3018 0", pc_F, pc_D, bd_D);
    end
    is_branch_D = 1'b1; Branch = 1'b0; imm16_D = 16'h0003;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, bd_D} !== {32'h3020, 32'h301c, 1'b1}) begin
      n_err++;
      $display("FAIL br_not_taken: pc_F=%h pc_D=%h bd=%b want 3020 301c 1", pc_F, pc_D, bd_D);
    end
    is_branch_D = 1'b1; Branch = 1'b1; imm16_D = 16'hfffe;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, bd_D} !== {32'h3018, 32'h3020, 1'b1}) begin
      n_err++;
      $display("FAIL br_backward: pc_F=%h pc_D=%h bd=%b want 3018 3020 1", pc_F, pc_D, bd_D);
    end
  endtask

  // Entry: pc_F=3018, pc_D=3020.
  task automatic test_jump();
    is_j_D = 1'b1; index26_D = 26'h0000_c40;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, bd_D} !== {32'h3100, 32'h3018, 1'b1}) begin
      n_err++;
      $display("FAIL j_target: pc_F=%h pc_D=%h bd=%b want 3100 3018 1", pc_F, pc_D, bd_D);
    end
    tick();
  endtask

  // Entry: pc_F=3104, pc_D=3100.
  task automatic test_jr_stall();
    is_jr_D = 1'b1; rs_val_D = 32'h0000_3202; stall = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({pc_F, pc_D, valid_D} !== {32'h3104, 32'h3100, 1'b1}) begin
        n_err++;
        $display("FAIL jr_stall_hold%0d: pc_F=%h pc_D=%h v=%b want 3104 3100 1", i, pc_F, pc_D, valid_D);
      end
    end
    stall = 1'b0;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, bd_D} !== {32'h3202, 32'h3104, 1'b1}) begin
      n_err++;
      $display("FAIL jr_release: pc_F=%h pc_D=%h bd=%b want 3202 3104 1", pc_F, pc_D, bd_D);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h3206, 32'h3202, ADEL_ON}) begin
      n_err++;
      $display("FAIL jr_misaligned_adel: pc_F=%h pc_D=%h adel=%b want 3206 3202 %b", pc_F, pc_D, adel_D, ADEL_ON);
    end
    tick();
  endtask

  // Entry: pc_F=320a, pc_D=3206.
  task automatic test_flush();
    stall = 1'b1; exc_req = 1'b1; eret_req = 1'b1; epc = 32'h0000_3044;
    tick();
    n_cmp++;
    if ({pc_F, pc_D, valid_D, bd_D, adel_D} !== {32'h4180, 32'h4180, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL exc_eret_stall: pc_F=%h pc_D=%h v=%b bd=%b adel=%b want 4180 4180 0 0 0",
               pc_F, pc_D, valid_D, bd_D, adel_D);
    end
    stall = 1'b0; exc_req = 1'b0;
    tick();
    eret_req = 1'b0;
    n_cmp++;
    if ({pc_F, pc_D, valid_D, bd_D} !== {32'h3044, 32'h3044, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL eret_redirect: pc_F=%h pc_D=%h v=%b bd=%b want 3044 3044 0 0", pc_F, pc_D, valid_D, bd_D);
    end
    is_j_D = 1'b1; index26_D = 26'h0000_c40;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D, valid_D, bd_D} !== {32'h3048, 32'h3044, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL invalid_d_gating: pc_F=%h pc_D=%h v=%b bd=%b want 3048 3044 1 0", pc_F, pc_D, valid_D, bd_D);
    end
  endtask

  // Entry: pc_F=3048, pc_D=3044.
  task automatic test_wrap();
    is_jr_D = 1'b1; rs_val_D = 32'hffff_fffc;
    tick();
    clear_ctl();
    n_cmp++;
    if ({pc_F, pc_D} !== {32'hffff_fffc, 32'h3048}) begin
      n_err++;
      $display("FAIL wrap_jr: pc_F=%h pc_D=%h want fffffffc 3048", pc_F, pc_D);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h0, 32'hffff_fffc, ADEL_ON}) begin
      n_err++;
      $display("FAIL wrap_zero: pc_F=%h pc_D=%h adel=%b want 0 fffffffc %b", pc_F, pc_D, adel_D, ADEL_ON);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h4, 32'h0, ADEL_ON}) begin
      n_err++;
      $display("FAIL below_base: pc_F=%h pc_D=%h adel=%b want 4 0 %b", pc_F, pc_D, adel_D, ADEL_ON);
    end
  endtask

  // Entry: pc_F=4, pc_D=0.
  task automatic test_reset_mid();
    is_branch_D = 1'b1; Branch = 1'b1; imm16_D = 16'h0003;
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pc_F, pc_D, valid_D} !== {32'h3000, 32'h3000, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: pc_F=%h pc_D=%h v=%b want 3000 3000 0", pc_F, pc_D, valid_D);
    end
    tick();
    clear_ctl();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({pc_F, valid_D} !== {32'h3000, 1'b0}) begin
      n_err++;
      $display("FAIL post_reset_fetch: pc_F=%h v=%b want 3000 0", pc_F, valid_D);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, valid_D} !== {32'h3004, 32'h3000, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_seq: pc_F=%h pc_D=%h v=%b want 3004 3000 1", pc_F, pc_D, valid_D);
    end
  endtask

  // Entry: pc_F=3004, pc_D=3000.
  task automatic test_range();
    is_jr_D = 1'b1; rs_val_D = 32'h0000_7000;
    tick();
    clear_ctl();
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h7004, 32'h7000, ADEL_ON}) begin
      n_err++;
      $display("FAIL above_top: pc_F=%h pc_D=%h adel=%b want 7004 7000 %b", pc_F, pc_D, adel_D, ADEL_ON);
    end
    is_jr_D = 1'b1; rs_val_D = 32'h0000_6ffc;
    tick();
    clear_ctl();
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h7000, 32'h6ffc, 1'b0}) begin
      n_err++;
      $display("FAIL at_top: pc_F=%h pc_D=%h adel=%b want 7000 6ffc 0", pc_F, pc_D, adel_D);
    end
    is_jr_D = 1'b1; rs_val_D = 32'h0000_2ffc;
    tick();
    clear_ctl();
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h3000, 32'h2ffc, ADEL_ON}) begin
      n_err++;
      $display("FAIL under_base: pc_F=%h pc_D=%h adel=%b want 3000 2ffc %b", pc_F, pc_D, adel_D, ADEL_ON);
    end
    tick();
    n_cmp++;
    if ({pc_F, pc_D, adel_D} !== {32'h3004, 32'h3000, 1'b0}) begin
      n_err++;
      $display("FAIL at_base: pc_F=%h pc_D=%h adel=%b want 3004 3000 0", pc_F, pc_D, adel_D);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_jr_stall();
    test_flush();
    test_wrap();
    test_reset_mid();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/npc_fetch_f.md
Name: npc_fetch_F

Overview:
- Fetch-stage next-PC unit and F→D PC pipeline register.
- Consumes the D-stage branch decision (`Branch`), D-stage jump decode and CP0 redirect requests.
- Drives the instruction-memory fetch address `pc_F`, and hands `pc_D`, `bd_D`, `valid_D` and `adel_D` to D/CP0 for exception attribution.
- Sits between the CP0/hazard unit and the IM/D-stage register file.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- EXC_HANDLER, 32'h0000_4180, exception/interrupt entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- stall, input, 1, hazard-unit freeze of F and the F/D register.
- Branch, input, 1, D-stage conditional branch taken.
- is_branch_D, input, 1, D instruction is beq/bne/bgez/bgtz/blez/bltz.
- is_j_D, input, 1, D instruction is j/jal.
- is_jr_D, input, 1, D instruction is jr/jalr.
- imm16_D, input, 16, branch offset field of the D instruction.
- index26_D, input, 26, jump index field of the D instruction.
- rs_val_D, input, 32, forwarded GPR[rs] in D.
- exc_req, input, 1, CP0 exception/interrupt redirect; flushes F/D.
- eret_req, input, 1, eret retire; redirect to epc; flushes F/D.
- epc, input, 32, CP0 EPC value.
- pc_F, output, 32, current fetch address.
- pc_D, output, 32, PC of the D-stage instruction.
- valid_D, output, 1, D holds a real (non-flushed) instruction.
- bd_D, output, 1, D instruction is in a branch delay slot.
- adel_D, output, 1, D instruction's fetch address was illegal.

Behaviour:
- Reset (reset = 0, asynchronous): pc_F = RESET_PC, pc_D = RESET_PC, valid_D = 0, bd_D = 0, adel_D = 0.
- Next-PC priority, evaluated every cycle:
  1. exc_req → EXC_HANDLER
  2. eret_req → epc
  3. stall → hold pc_F
  4. is_branch_D & Branch → pc_D + 4 + (sext(imm16_D) << 2)
  5. is_j_D → {pc_D_plus4[31:28], index26_D, 2'b00}
  6. is_jr_D → rs_val_D
  7. otherwise → pc_F + 4
- Arithmetic is 32-bit modulo: pc_F = 32'hffff_fffc wraps to 0 on +4; no carry is kept.
- Jump-class decode (j, jr, branch) is ignored when valid_D = 0.
- Branch not taken: the fall-through is pc_F + 4, with no extra bubble. The delay slot, already in F, executes in both cases.
- F/D register update:
  - exc_req or eret_req: valid_D←0, bd_D←0, adel_D←0, pc_D←next-PC value. Flush has priority over stall. eret has no delay slot.
  - else stall: all D outputs hold.
  - else: pc_D←pc_F, valid_D←1, bd_D←valid_D & (is_branch_D | is_j_D | is_jr_D), adel_D←illegal(pc_F).
- bd_D is set on every branch, taken or not.
- illegal(a) = (a[1:0] ≠ 0) | (a < IM_BASE) | (a > IM_TOP).
- An illegal fetch address is still presented on pc_F; the IM result is discarded downstream via adel_D. The PC keeps advancing normally until CP0 asserts exc_req.
- Simultaneous exc_req and eret_req: exc_req wins.
- Redirect during stall: a D-stage branch or jump under stall is not applied; it is re-evaluated when stall drops, because D inputs are held.
- Reset mid-operation: abandons any redirect. The first fetch after reset release is RESET_PC.
- Latency: a redirect decided in cycle n appears on pc_F in cycle n+1.

Optional Feature:
- Macro: NPC_FETCH_ADEL_EN.
- Defined: illegal-address detection as above drives adel_D.
- Undefined: adel_D is constant 0 and the range/alignment comparators are not built. All other behaviour is unchanged.

Test Plan:
- Release reset, no stall, no jumps, 4 cycles → pc_F = 3000, 3004, 3008, 300c; valid_D = 1 from cycle 2; bd_D = 0.
- beq in D at pc_D = 3008, Branch = 1, imm16_D = 16'h0003 → next pc_F = 3018; the delay-slot instruction at 300c reaches D with bd_D = 1. Repeat with Branch = 0 → next pc_F = 3010, and bd_D is still 1.
- jr in D, rs_val_D = 32'h0000_3202, stall held 2 cycles, then released:
  - pc_F holds during the stall.
  - After release, pc_F = 3202.
  - When that address reaches D (macro defined): adel_D = 1, pc_D = 3202.
- exc_req and eret_req together while stall = 1 → pc_F = 4180, valid_D = 0, bd_D = 0 next cycle. Then eret_req alone with epc = 3044 → pc_F = 3044 with no delay slot.
- Drive reset low asynchronously mid-cycle during a taken branch → pc_F = 3000 immediately and valid_D = 0. First fetch after release is 3000.
- Macro undefined, pc_F driven to 32'h0000_7000 via jr → adel_D stays 0; pc_F sequence 7000, 7004.
